// File: rtl/fp64_mul_norm_round.sv
// Back-end of the pipelined binary64 multiplier: aligns operand side info with the
// mantissa product, then normalises, rounds to nearest-even, resolves specials and packs.
module fp64_mul_norm_round #(
    parameter int MUL_LAT = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         valid_in,
    input  logic [63:0]  a_in,
    input  logic [63:0]  b_in,
    input  logic [127:0] prod_in,
    output logic         valid_out,
    output logic [63:0]  result,
    output logic         flag_invalid,
    output logic         flag_overflow,
    output logic         flag_underflow,
    output logic         flag_inexact
);

    typedef struct packed {
        logic              valid;
        logic              s;
        logic signed [12:0] e;
        logic              any_nan;
        logic              any_snan;
        logic              any_inf;
        logic              any_zero;
    } side_t;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    // Operand class as {zero, inf, nan, snan}; subnormals count as zero
    function automatic logic [3:0] classify(input logic [63:0] x);
        logic exp_zero;
        logic exp_max;
        logic frac_zero;
        exp_zero  = (x[62:52] == 11'd0);
        exp_max   = (x[62:52] == 11'h7FF);
        frac_zero = (x[51:0] == 52'd0);
        return {exp_zero, exp_max & frac_zero, exp_max & ~frac_zero,
                exp_max & ~frac_zero & ~x[51]};
    endfunction

    logic [3:0]         a_cls_s;
    logic [3:0]         b_cls_s;
    side_t              cap_s;
    side_t              dly_r [MUL_LAT];
    side_t              pair_s;
    logic               unused_prod_s;

    logic [51:0]        n1_m_s;
    logic               n1_g_s;
    logic               n1_st_s;
    logic signed [12:0] n1_e_s;

    logic               n1_valid_r;
    logic               n1_s_r;
    logic signed [12:0] n1_e_r;
    logic               n1_nan_r;
    logic               n1_snan_r;
    logic               n1_inf_r;
    logic               n1_zero_r;
    logic [51:0]        n1_m_r;
    logic               n1_g_r;
    logic               n1_st_r;

    logic               rnd_s;
    logic [52:0]        m_sum_s;
    logic [51:0]        m_rnd_s;
    logic signed [12:0] e_rnd_s;
    logic               inexact_raw_s;
    logic [63:0]        res_s;
    logic [3:0]         flags_s;

    assign unused_prod_s = ^prod_in[127:106];
    assign pair_s        = dly_r[MUL_LAT-1];

    // Capture sign, biased exponent sum and operand classes on entry
    always_comb begin
        a_cls_s        = classify(a_in);
        b_cls_s        = classify(b_in);
        cap_s.valid    = valid_in;
        cap_s.s        = a_in[63] ^ b_in[63];
        cap_s.e        = $signed({2'b00, a_in[62:52]} + {2'b00, b_in[62:52]} - 13'd1023);
        cap_s.any_zero = a_cls_s[3] | b_cls_s[3];
        cap_s.any_inf  = a_cls_s[2] | b_cls_s[2];
        cap_s.any_nan  = a_cls_s[1] | b_cls_s[1];
        cap_s.any_snan = a_cls_s[0] | b_cls_s[0];
    end

    // Side-info delay line matching the mantissa multiplier latency
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                dly_r[i] <= '0;
            end
        end else begin
            dly_r[0] <= cap_s;
            for (int i = 1; i < MUL_LAT; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    // Normalise: the product of two [1,2) significands lies in [1,4)
    always_comb begin
        if (prod_in[105]) begin
            n1_m_s  = prod_in[104:53];
            n1_g_s  = prod_in[52];
            n1_st_s = |prod_in[51:0];
            n1_e_s  = pair_s.e + 13'sd1;
        end else begin
            n1_m_s  = prod_in[103:52];
            n1_g_s  = prod_in[51];
            n1_st_s = |prod_in[50:0];
            n1_e_s  = pair_s.e;
        end
    end

    // Stage N1 register; payload loads only for valid items
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            n1_valid_r <= 1'b0;
            n1_s_r     <= 1'b0;
            n1_e_r     <= 13'sd0;
            n1_nan_r   <= 1'b0;
            n1_snan_r  <= 1'b0;
            n1_inf_r   <= 1'b0;
            n1_zero_r  <= 1'b0;
            n1_m_r     <= 52'd0;
            n1_g_r     <= 1'b0;
            n1_st_r    <= 1'b0;
        end else begin
            n1_valid_r <= pair_s.valid;
            if (pair_s.valid) begin
                n1_s_r    <= pair_s.s;
                n1_e_r    <= n1_e_s;
                n1_nan_r  <= pair_s.any_nan;
                n1_snan_r <= pair_s.any_snan;
                n1_inf_r  <= pair_s.any_inf;
                n1_zero_r <= pair_s.any_zero;
                n1_m_r    <= n1_m_s;
                n1_g_r    <= n1_g_s;
                n1_st_r   <= n1_st_s;
            end
        end
    end

    // Round to nearest-even, then pick the result by special-case priority
    always_comb begin
        rnd_s         = n1_g_r & (n1_st_r | n1_m_r[0]);
        m_sum_s       = {1'b0, n1_m_r} + {52'd0, rnd_s};
        inexact_raw_s = n1_g_r | n1_st_r;
        if (m_sum_s[52]) begin
            m_rnd_s = 52'd0;
            e_rnd_s = n1_e_r + 13'sd1;
        end else begin
            m_rnd_s = m_sum_s[51:0];
            e_rnd_s = n1_e_r;
        end
        res_s   = 64'd0;
        flags_s = 4'b0000;
        if (n1_nan_r) begin
            res_s   = QNAN;
            flags_s = {n1_snan_r, 3'b000};
        end else if (n1_inf_r && n1_zero_r) begin
            res_s   = QNAN;
            flags_s = 4'b1000;
        end else if (n1_inf_r) begin
            res_s   = {n1_s_r, 11'h7FF, 52'd0};
            flags_s = 4'b0000;
        end else if (n1_zero_r) begin
            res_s   = {n1_s_r, 63'd0};
            flags_s = 4'b0000;
        end else if (e_rnd_s >= 13'sd2047) begin
            res_s   = {n1_s_r, 11'h7FF, 52'd0};
            flags_s = 4'b0101;
        end else if (e_rnd_s <= 13'sd0) begin
            res_s   = {n1_s_r, 63'd0};
            flags_s = 4'b0011;
        end else begin
            res_s   = {n1_s_r, e_rnd_s[10:0], m_rnd_s};
            flags_s = {3'b000, inexact_raw_s};
        end
    end

    // Output register; result and flags hold while no valid item arrives
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_out      <= 1'b0;
            result         <= 64'd0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            valid_out <= n1_valid_r;
            if (n1_valid_r) begin
                result         <= res_s;
                flag_invalid   <= flags_s[3];
                flag_overflow  <= flags_s[2];
                flag_underflow <= flags_s[1];
                flag_inexact   <= flags_s[0];
            end
        end
    end

endmodule

// File: tb/tb_fp64_mul_norm_round.sv
// Directed bench for fp64_mul_norm_round with a behavioural mantissa multiplier
// feeding prod_in and a reference model for the streamed items.
module tb_fp64_mul_norm_round;

    localparam int MUL_LAT = 4;
    localparam int LAT     = MUL_LAT + 2;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         valid_in = 1'b0;
    logic [63:0]  a_in = 64'd0;
    logic [63:0]  b_in = 64'd0;
    logic [127:0] prod_in;
    logic         valid_out;
    logic [63:0]  result;
    logic         flag_invalid;
    logic         flag_overflow;
    logic         flag_underflow;
    logic         flag_inexact;
    logic [3:0]   fl;

    logic [127:0] mpipe [MUL_LAT];

    int total = 0;
    int bad   = 0;

    logic [63:0] sa [10];
    logic [63:0] sb [10];

    fp64_mul_norm_round #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .nrst(nrst), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
        .prod_in(prod_in), .valid_out(valid_out), .result(result),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
    );

    assign fl      = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};
    assign prod_in = mpipe[MUL_LAT-1];

    always #5 clk = ~clk;

    // Stand-in for the upstream mantissa multiplier
    always @(posedge clk) begin
        mpipe[0] <= {75'd0, 1'b1, a_in[51:0]} * {75'd0, 1'b1, b_in[51:0]};
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference for normal operands: round the exact product by remainder vs half-ulp
    task automatic ref_mul(input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] r, output logic [3:0] f);
        logic [105:0] p, rem, half;
        logic [53:0]  q;
        logic [10:0]  ef;
        logic         s, inx;
        int           sh, ex;
        s    = a[63] ^ b[63];
        p    = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
        sh   = p[105] ? 53 : 52;
        q    = 54'(p >> sh);
        rem  = p & ((106'd1 << sh) - 106'd1);
        half = 106'd1 << (sh - 1);
        inx  = (rem != 106'd0);
        ex   = int'(a[62:52]) + int'(b[62:52]) - 1023 + (sh - 52);
        if (rem > half || (rem == half && q[0])) q = q + 54'd1;
        if (q[53]) begin
            q  = q >> 1;
            ex = ex + 1;
        end
        ef = ex[10:0];
        if (ex >= 2047) begin
            r = {s, 11'h7FF, 52'd0};
            f = 4'b0101;
        end else if (ex <= 0) begin
            r = {s, 63'd0};
            f = 4'b0011;
        end else begin
            r = {s, ef, q[51:0]};
            f = {3'b000, inx};
        end
    endtask

    function automatic logic [63:0] rnd_norm();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[62:52] = 11'(900 + $urandom_range(0, 246));
        return r;
    endfunction

    // Single isolated operation; entered and left at #1 after a rising edge
    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] er, input logic [3:0] ef);
        int n;
        valid_in = 1'b1;
        a_in     = a;
        b_in     = b;
        n        = 0;
        do begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            n++;
        end while (!valid_out && n < 20);
        chk({tag, "_lat"}, 64'(n), 64'(LAT));
        chk({tag, "_res"}, result, er);
        chk({tag, "_flg"}, {60'd0, fl}, {60'd0, ef});
    endtask

    initial begin
        logic [63:0] er;
        logic [3:0]  ef;
        logic        exp_v;
        int          idx;

        #12;
        chk("rst_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", {60'd0, fl}, 64'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        run_one("mul_1p5x2", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 4'b0000);
        run_one("tie_even", 64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002, 4'b0001);
        run_one("sticky", 64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002, 4'b0001);
        run_one("ovf_pos", 64'h7FE0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 4'b0101);
        run_one("ovf_neg", 64'hFFE0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 4'b0101);
        run_one("unf_ftz", 64'h0010000000000000, 64'hBFE0000000000000, 64'h8000000000000000, 4'b0011);
        run_one("daz", 64'h0000000000000001, 64'h4000000000000000, 64'h0000000000000000, 4'b0000);
        run_one("inf_x_0", 64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 4'b1000);
        run_one("snan", 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 4'b1000);
        run_one("qnan", 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 4'b0000);
        run_one("ninf_x3", 64'hFFF0000000000000, 64'h4008000000000000, 64'hFFF0000000000000, 4'b0000);

        // Bubbles must leave result untouched
        repeat (3) @(posedge clk);
        #1;
        chk("hold_valid", {63'd0, valid_out}, 64'd0);
        chk("hold_result", result, 64'hFFF0000000000000);

        for (int i = 0; i < 10; i++) begin
            sa[i] = rnd_norm();
            sb[i] = rnd_norm();
        end

        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            a_in     = sa[i];
            b_in     = sb[i];
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        nrst     = 1'b0;
        #1;
        chk("arst_valid", {63'd0, valid_out}, 64'd0);
        chk("arst_result", result, 64'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        for (int c = 0; c < 20; c++) begin
            if (c < 6) begin
                valid_in = 1'b1;
                a_in     = sa[4 + c];
                b_in     = sb[4 + c];
            end else begin
                valid_in = 1'b0;
            end
            @(posedge clk);
            #1;
            exp_v = (c + 1 >= LAT) && (c + 1 - LAT < 6);
            chk($sformatf("strm_valid_c%0d", c), {63'd0, valid_out}, {63'd0, exp_v});
            if (exp_v) begin
                idx = 4 + c + 1 - LAT;
                ref_mul(sa[idx], sb[idx], er, ef);
                chk($sformatf("strm_res_%0d", idx), result, er);
                chk($sformatf("strm_flg_%0d", idx), {60'd0, fl}, {60'd0, ef});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp64_mul_norm_round.md
Name: fp64_mul_norm_round

Overview:
- Back-end stage of the pipelined double-precision multiplier. Sits directly downstream of the 64x64 Booth/Wallace mantissa multiplier and consumes its 128-bit product.
- Receives the raw IEEE-754 operands on the same cycle they enter the mantissa multiplier. Extracts sign, exponent and special-class info, then delays it to line up with the product.
- Normalises, rounds (nearest-even), handles specials, and packs the final binary64 result.
- Flush-to-zero and denormals-are-zero; no backpressure.

Parameters:
- MUL_LAT, 4, cycles from operands at the mantissa multiplier's A/B inputs to the matching product on prod_in. Must equal the multiplier's latency.

Ports:
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  asynchronous active-low reset
- valid_in  in  1  a_in/b_in valid this cycle (same cycle as multiplier A/B)
- a_in  in  64  operand A, raw binary64
- b_in  in  64  operand B, raw binary64
- prod_in  in  128  mantissa product {11'b0,1,fa}x{11'b0,1,fb}; bits 127:106 ignored
- valid_out  out  1  result/flags valid
- result  out  64  packed binary64 product
- flag_invalid  out  1  inf x 0, or any signalling NaN input
- flag_overflow  out  1  rounded result exceeded max finite
- flag_underflow  out  1  rounded result below min normal, flushed to zero
- flag_inexact  out  1  result differs from exact product

Behaviour:
- Reset: nrst is asynchronous, active-low; clock is clk. While nrst=0, all valid bits, side-info delay stages and pipeline registers are cleared; valid_out, result and all flags are 0.
- Reset mid-operation discards every in-flight item. After release, valid_out stays 0 until a new valid_in has propagated through.
- Latency: valid_out rises exactly MUL_LAT+2 cycles after valid_in. Throughput is 1 per cycle; bubbles pass through as valid_out=0.
- When valid_out=0, result and flags hold their last values.
- Capture (cycle 0): s = a[63]^b[63]; e = a[62:52] + b[62:52] - 1023, held as 13-bit signed.
- Capture classification per operand:
  - zero if exp==0 (subnormals treated as zero);
  - inf if exp==2047 and frac==0;
  - NaN if exp==2047 and frac!=0;
  - sNaN if NaN and frac[51]==0.
- Side info {valid,s,e,class bits} passes through a MUL_LAT-deep shift register and is paired with prod_in in the cycle it emerges.
- Stage N1 (registered), normalise:
  - if P[105]=1: m=P[104:53], G=P[52], S=|P[51:0], e=e+1;
  - else: m=P[103:52], G=P[51], S=|P[50:0].
- Stage N2 (registered output):
  - rnd = G & (S | m[0]); m = m + rnd.
  - On carry-out of m: m=0, e=e+1.
  - inexact_raw = G|S.
- Output priority, first match wins:
  1. any NaN -> 0x7FF8000000000000, invalid = any sNaN.
  2. inf x zero -> 0x7FF8000000000000, invalid=1.
  3. inf x (finite or inf) -> {s,0x7FF,52'b0}.
  4. zero operand -> {s,63'b0}; no flags set.
  5. e >= 2047 after rounding -> {s,0x7FF,52'b0}, overflow=1, inexact=1.
  6. e <= 0 after rounding -> {s,63'b0}, underflow=1, inexact=1.
  7. otherwise -> {s,e[10:0],m}, inexact = inexact_raw.
- Only the flags named in the matching rule may be 1 for that result.
- prod_in is sampled only when the delayed valid is 1. Its value is ignored for special-class items.

Test Plan:
- 1.5 x 2.0: a=0x3FF8000000000000, b=0x4000000000000000 -> result=0x4008000000000000, all flags 0, valid_out exactly MUL_LAT+2 cycles after valid_in.
- Tie-to-even round-up: a=0x3FF0000000000001, b=0x3FF8000000000000 -> 0x3FF8000000000002, inexact=1. Sticky-only case a=b=0x3FF0000000000001 -> 0x3FF0000000000002, inexact=1.
- Overflow: a=0x7FE0000000000000, b=0x4000000000000000 -> 0x7FF0000000000000, overflow=1, inexact=1. Same with a sign-flipped -> 0xFFF0000000000000.
- Underflow/FTZ: a=0x0010000000000000, b=0xBFE0000000000000 -> 0x8000000000000000, underflow=1, inexact=1. Subnormal a=0x0000000000000001 x 2.0 -> 0x0000000000000000, no flags.
- Specials:
  - 0x7FF0000000000000 x 0 -> 0x7FF8000000000000, invalid=1;
  - sNaN 0x7FF0000000000001 x 1.0 -> 0x7FF8000000000000, invalid=1;
  - qNaN 0x7FF8000000000000 x 1.0 -> same result, invalid=0;
  - -inf x 3.0 -> 0xFFF0000000000000.
- Streaming + reset: 10 back-to-back random normal pairs (bench models prod_in as the MUL_LAT-delayed exact mantissa product). Pull nrst low for 1 cycle after item 4 enters.
  - Required: valid_out=0 and result=0 asynchronously during reset.
  - No pre-reset item ever appears at the output.
  - Post-reset items match a reference model bit-exactly, with correct latency and order.
